fp_align_stage: RTL and testbench

- Iterative exponent-compare and mantissa-alignment stage. It sits directly upstream of the 32-bit floating-point mantissa add/normalise stage.
- Accepts two IEEE-754 single-precision operands and orders them by magnitude.
- Right-shifts the smaller mantissa one bit per clock, using a down-counter built from the team's flip-flop primitives. Guard, round and sticky bits are preserved.
- Hands aligned operands downstream over a valid/ready handshake.

---
 rtl/fp_align_stage_pkg.sv | 44 ++++
 rtl/fp_align_stage_if.sv | 36 +++
 rtl/fp_shift_ctr.sv | 45 ++++
 rtl/fp_align_stage.sv | 184 ++++++++++++++++++
 tb/tb_fp_align_stage.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/fp_align_stage_pkg.sv
// fp_align_stage_pkg
// Shared constants, FSM encoding and an operand-unpack helper for the
// floating-point alignment stage and its down-counter.
//   EXP_W / MANT_W : IEEE single exponent and stored-fraction widths
//   AL_W           : aligned mantissa width (hidden + fraction + G/R/S)
//   MAX_SHIFT      : alignment shift cap (equals AL_W)
//   CNT_W          : shift counter width
package fp_align_stage_pkg;

    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MANT_W    = 23;
    localparam int unsigned AL_W      = 27;
    localparam int unsigned MAX_SHIFT = 27;
    localparam int unsigned CNT_W     = 5;

    localparam logic [EXP_W-1:0] EXP_ALL1 = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp_raw;
        logic [EXP_W-1:0]  exp_eff;
        logic              hidden;
        logic [MANT_W-1:0] frac;
    } fp_unpack_t;

    // Denormals (exponent 0) have no hidden bit and behave as exponent 1.
    function automatic fp_unpack_t fp_unpack(input logic [31:0] x);
        fp_unpack_t u;
        u.sign    = x[31];
        u.exp_raw = x[30:23];
        u.hidden  = |x[30:23];
        u.exp_eff = u.hidden ? x[30:23] : 8'd1;
        u.frac    = x[22:0];
        return u;
    endfunction

endpackage

// File: rtl/fp_align_stage_if.sv
// fp_align_stage_if
// Handshake and data bundle between the operand source, the alignment
// stage and the downstream add/normalise stage.
//   in_valid/in_ready   : operand pair handshake, A/B operands
//   out_valid/out_ready : aligned result handshake
//   ExpOut, MantL, MantS, SignL, SignS, Swap, Special : aligned result
// Modports: master = surrounding logic (drives operands, consumes result),
//           slave  = the alignment stage.
interface fp_align_stage_if;
    import fp_align_stage_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       A;
    logic [31:0]       B;
    logic              out_valid;
    logic              out_ready;
    logic [EXP_W-1:0]  ExpOut;
    logic [AL_W-1:0]   MantL;
    logic [AL_W-1:0]   MantS;
    logic              SignL;
    logic              SignS;
    logic              Swap;
    logic              Special;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, ExpOut, MantL, MantS, SignL, SignS, Swap, Special
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, ExpOut, MantL, MantS, SignL, SignS, Swap, Special
    );

endinterface

// File: rtl/fp_shift_ctr.sv
// fp_shift_ctr
// 5-bit synchronous loadable down-counter used to pace mantissa shifts.
//   Clk   : rising-edge clock
//   Rst   : synchronous active-high reset, clears Q
//   Load  : load D into Q (has priority over Dec)
//   Dec   : decrement Q by one
//   D     : load value
//   Q     : current count
//   IsOne : Q == 1, i.e. the current decrement is the last one
module fp_shift_ctr
    import fp_align_stage_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load,
    input  logic             Dec,
    input  logic [CNT_W-1:0] D,
    output logic [CNT_W-1:0] Q,
    output logic             IsOne
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (Load) begin
            w_cnt_next = D;
        end else if (Dec) begin
            w_cnt_next = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign Q     = r_cnt;
    assign IsOne = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/fp_align_stage.sv
// fp_align_stage
// Iterative exponent compare and mantissa alignment ahead of the FP adder.
// Registers an operand pair, orders it by magnitude, then right-shifts the
// smaller mantissa one bit per clock (sticky-accumulating into bit 0) until
// both share the larger exponent, and presents the result on a valid/ready
// handshake.
//   Clk : rising-edge clock
//   Rst : synchronous active-high reset; returns to IDLE, clears all state
//   bus : fp_align_stage_if.slave (operand input, aligned result output)
module fp_align_stage
    import fp_align_stage_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst,
    fp_align_stage_if.slave      bus
);

    state_e r_state;
    state_e w_state_next;

    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [EXP_W-1:0] r_exp_out;
    logic [AL_W-1:0]  r_mant_l;
    logic [AL_W-1:0]  r_mant_s;
    logic             r_sign_l;
    logic             r_sign_s;
    logic             r_swap;
    logic             r_special;

    fp_unpack_t       w_ua;
    fp_unpack_t       w_ub;
    fp_unpack_t       w_ul;
    fp_unpack_t       w_us;
    logic             w_a_larger;
    logic [EXP_W-1:0] w_diff;
    logic [CNT_W-1:0] w_shift_cnt;
    logic             w_special;

    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt_q;
    logic             w_cnt_is_one;

    // ---------------------------------------------------------------------
    // Compare / unpack (evaluated from the registered operands in CMP)
    // ---------------------------------------------------------------------
    always_comb begin
        w_ua = fp_unpack(r_a);
        w_ub = fp_unpack(r_b);
        // Including the hidden bit keeps the order correct when a denormal
        // (effective exponent 1) meets a normal with raw exponent 1.
        w_a_larger = (w_ua.exp_eff > w_ub.exp_eff) ||
                     ((w_ua.exp_eff == w_ub.exp_eff) &&
                      ({w_ua.hidden, w_ua.frac} >= {w_ub.hidden, w_ub.frac}));
        w_ul = w_a_larger ? w_ua : w_ub;
        w_us = w_a_larger ? w_ub : w_ua;
        w_diff = w_ul.exp_eff - w_us.exp_eff;
        w_shift_cnt = (w_diff > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : w_diff[CNT_W-1:0];
        w_special = (w_ua.exp_raw == EXP_ALL1) || (w_ub.exp_raw == EXP_ALL1);
    end

    // ---------------------------------------------------------------------
    // Shift counter
    // ---------------------------------------------------------------------
    assign w_cnt_load = (r_state == CMP);
    assign w_cnt_dec  = (r_state == SHIFT);

    fp_shift_ctr u_shift_ctr (
        .Clk   (Clk),
        .Rst   (Rst),
        .Load  (w_cnt_load),
        .Dec   (w_cnt_dec),
        .D     (w_shift_cnt),
        .Q     (w_cnt_q),
        .IsOne (w_cnt_is_one)
    );

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = CMP;
                end
            end
            CMP: begin
                if (w_special || (w_shift_cnt == '0)) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                // The zero check only guards against a stuck counter.
                if (w_cnt_is_one || (w_cnt_q == '0)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (r_state)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_exp_out <= '0;
            r_mant_l  <= '0;
            r_mant_s  <= '0;
            r_sign_l  <= 1'b0;
            r_sign_s  <= 1'b0;
            r_swap    <= 1'b0;
            r_special <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a <= bus.A;
                        r_b <= bus.B;
                    end
                end
                CMP: begin
                    r_exp_out <= w_ul.exp_raw;
                    r_mant_l  <= {w_ul.hidden, w_ul.frac, 3'b000};
                    r_mant_s  <= {w_us.hidden, w_us.frac, 3'b000};
                    r_sign_l  <= w_ul.sign;
                    r_sign_s  <= w_us.sign;
                    r_swap    <= ~w_a_larger;
                    r_special <= w_special;
                end
                SHIFT: begin
                    // Bits falling off the end fold into the sticky bit.
                    r_mant_s <= {1'b0, r_mant_s[AL_W-1:2], r_mant_s[1] | r_mant_s[0]};
                end
                default: ;
            endcase
        end
    end

    assign bus.ExpOut  = r_exp_out;
    assign bus.MantL   = r_mant_l;
    assign bus.MantS   = r_mant_s;
    assign bus.SignL   = r_sign_l;
    assign bus.SignS   = r_sign_s;
    assign bus.Swap    = r_swap;
    assign bus.Special = r_special;

endmodule

// File: tb/tb_fp_align_stage.sv
// tb_fp_align_stage
// Directed bench for fp_align_stage: hand-computed operand pairs covering
// ordering, latency, sticky capture, shift cap, Inf handling, backpressure
// and mid-operation reset.
module tb_fp_align_stage;

    logic Clk = 1'b0;
    logic Rst;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    always #5 Clk = ~Clk;

    fp_align_stage_if bus ();

    fp_align_stage dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Present a pair for one accepting edge, then count cycles until out_valid.
    // The cycle right after the accepting edge is counted as 1.
    task automatic run_pair(input logic [31:0] a, input logic [31:0] b, output int l);
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(posedge Clk);
        #1;
        bus.in_valid = 1'b0;
        l = 1;
        while (!bus.out_valid && l < 100) begin
            @(posedge Clk);
            #1;
            l++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge Clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        Rst           = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;

        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mants", {5'd0, bus.MantS}, 32'd0);
        chk("rst_expout", {24'd0, bus.ExpOut}, 32'd0);

        // 1.0 vs 1.0: full tie, A wins, no shift
        run_pair(32'h3F800000, 32'h3F800000, lat);
        chk("eq_latency", lat, 2);
        chk("eq_expout", {24'd0, bus.ExpOut}, 32'h7F);
        chk("eq_mantl", {5'd0, bus.MantL}, 32'h4000000);
        chk("eq_mants", {5'd0, bus.MantS}, 32'h4000000);
        chk("eq_swap", {31'd0, bus.Swap}, 32'd0);
        chk("eq_special", {31'd0, bus.Special}, 32'd0);
        chk("eq_in_ready", {31'd0, bus.in_ready}, 32'd0);
        release_out();

        // 1.0 vs 3.0: d=1, B larger
        run_pair(32'h3F800000, 32'h40400000, lat);
        chk("d1_latency", lat, 3);
        chk("d1_swap", {31'd0, bus.Swap}, 32'd1);
        chk("d1_expout", {24'd0, bus.ExpOut}, 32'h80);
        chk("d1_mantl", {5'd0, bus.MantL}, 32'h6000000);
        chk("d1_mants", {5'd0, bus.MantS}, 32'h2000000);
        release_out();

        // 2^24 vs 1.0+ulp: d=24, lsb ends in sticky
        run_pair(32'h4B800000, 32'h3F800001, lat);
        chk("sticky_latency", lat, 26);
        chk("sticky_expout", {24'd0, bus.ExpOut}, 32'h97);
        chk("sticky_mantl", {5'd0, bus.MantL}, 32'h4000000);
        chk("sticky_mants", {5'd0, bus.MantS}, 32'h0000005);
        // Backpressure: result must hold for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            #1;
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_mants", {5'd0, bus.MantS}, 32'h0000005);
            chk("bp_mantl", {5'd0, bus.MantL}, 32'h4000000);
            chk("bp_expout", {24'd0, bus.ExpOut}, 32'h97);
        end
        release_out();

        // 2^127 vs 1.0: d=127, capped at 27 shifts
        run_pair(32'h7F000000, 32'h3F800000, lat);
        chk("cap_latency", lat, 29);
        chk("cap_mants", {5'd0, bus.MantS}, 32'h0000001);
        chk("cap_expout", {24'd0, bus.ExpOut}, 32'hFE);
        release_out();

        // +Inf vs 1.0: special, no shift
        run_pair(32'h7F800000, 32'h3F800000, lat);
        chk("inf_latency", lat, 2);
        chk("inf_special", {31'd0, bus.Special}, 32'd1);
        chk("inf_expout", {24'd0, bus.ExpOut}, 32'hFF);
        chk("inf_mants", {5'd0, bus.MantS}, 32'h4000000);
        chk("inf_swap", {31'd0, bus.Swap}, 32'd0);
        release_out();

        // 1.0 vs -1.5: equal exponents, fraction decides, signs swapped
        run_pair(32'h3F800000, 32'hBFC00000, lat);
        chk("neg_latency", lat, 2);
        chk("neg_swap", {31'd0, bus.Swap}, 32'd1);
        chk("neg_signl", {31'd0, bus.SignL}, 32'd1);
        chk("neg_signs", {31'd0, bus.SignS}, 32'd0);
        chk("neg_mantl", {5'd0, bus.MantL}, 32'h6000000);
        chk("neg_mants", {5'd0, bus.MantS}, 32'h4000000);
        release_out();

        // Reset in the middle of a d=20 shift sequence
        bus.A        = 32'h49800000;
        bus.B        = 32'h3F800000;
        bus.in_valid = 1'b1;
        @(posedge Clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        chk("mid_busy", {31'd0, bus.in_ready}, 32'd0);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_mants", {5'd0, bus.MantS}, 32'd0);
        chk("mid_rst_expout", {24'd0, bus.ExpOut}, 32'd0);

        run_pair(32'h3F800000, 32'h40400000, lat);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_mants", {5'd0, bus.MantS}, 32'h2000000);
        chk("post_rst_swap", {31'd0, bus.Swap}, 32'd1);
        release_out();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
